// File: rtl/pool_stream_top.sv
`default_nettype none
// ============================================================================
//  Module      : pool_stream_top
//  Description : Streaming channel-parallel KxK max/average pooling. Pixels
//                arrive in raster order with a valid/ready handshake; partial
//                window results live in a row buffer of IMG_W/K entries, and
//                one pooled pixel per channel leaves per completed window.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_stream_top #(
    parameter int BITS    = 16,
    parameter int CH      = 8,
    parameter int IMG_W   = 24,
    parameter int IMG_H   = 24,
    parameter int K       = 2,
    parameter int K_SHIFT = 1
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*BITS-1:0]   data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*BITS-1:0]   data_out,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    // Accumulator holds a full KxK sum without overflow.
    localparam int c_ACC_W  = BITS + 2 * K_SHIFT;
    localparam int c_GROUPS = IMG_W / K;
    localparam int c_COL_W  = $clog2(IMG_W);
    localparam int c_ROW_W  = $clog2(IMG_H);
    localparam int c_GIDX_W = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic                  r_mode;
    logic [c_COL_W-1:0]    r_col;
    logic [c_ROW_W-1:0]    r_row;
    logic                  r_all_in;
    logic [CH*c_ACC_W-1:0] r_hacc;
    logic [CH*c_ACC_W-1:0] r_rowbuf [0:c_GROUPS-1];
    logic                  r_out_valid;
    logic [CH*BITS-1:0]    r_data_out;
    logic                  r_out_last;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_out_fire;
    logic                  w_grp_first;
    logic                  w_grp_end;
    logic                  w_row_first;
    logic                  w_row_end;
    logic                  w_col_end;
    logic                  w_row_last;
    logic                  w_win_done;
    logic [c_GIDX_W-1:0]   w_gidx;
    logic [CH*c_ACC_W-1:0] w_hval_all;
    logic [CH*c_ACC_W-1:0] w_wr_all;
    logic [CH*BITS-1:0]    w_out_all;

    // A stalled full output register blocks every beat, so a completing
    // beat can never overwrite an unconsumed result.
    assign w_in_ready  = (r_state == c_S_RUN) & ~(r_out_valid & ~out_ready) & ~r_all_in;
    assign w_accept    = in_valid & w_in_ready;
    assign w_out_fire  = r_out_valid & out_ready;
    assign w_grp_first = (r_col[K_SHIFT-1:0] == '0);
    assign w_grp_end   = (r_col[K_SHIFT-1:0] == K_SHIFT'(K - 1));
    assign w_row_first = (r_row[K_SHIFT-1:0] == '0);
    assign w_row_end   = (r_row[K_SHIFT-1:0] == K_SHIFT'(K - 1));
    assign w_col_end   = (r_col == c_COL_W'(IMG_W - 1));
    assign w_row_last  = (r_row == c_ROW_W'(IMG_H - 1));
    assign w_win_done  = w_accept & w_grp_end & w_row_end;
    assign w_gidx      = c_GIDX_W'(r_col >> K_SHIFT);

    // Per-channel datapath: horizontal reduction, vertical combine with the
    // row buffer entry, and final scaling to the output width.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic signed [BITS-1:0]    w_pix;
        logic signed [c_ACC_W-1:0] w_pix_ext;
        logic signed [c_ACC_W-1:0] w_hacc;
        logic signed [c_ACC_W-1:0] w_hval;
        logic signed [c_ACC_W-1:0] w_buf;
        logic signed [c_ACC_W-1:0] w_comb;

        assign w_pix     = data_in[g*BITS +: BITS];
        assign w_pix_ext = {{(2*K_SHIFT){w_pix[BITS-1]}}, w_pix};
        assign w_hacc    = r_hacc[g*c_ACC_W +: c_ACC_W];
        assign w_hval    = w_grp_first ? w_pix_ext :
                           (r_mode ? (w_hacc + w_pix_ext) :
                                     ((w_pix_ext > w_hacc) ? w_pix_ext : w_hacc));
        assign w_buf     = r_rowbuf[w_gidx][g*c_ACC_W +: c_ACC_W];
        assign w_comb    = r_mode ? (w_buf + w_hval) :
                                    ((w_hval > w_buf) ? w_hval : w_buf);

        assign w_hval_all[g*c_ACC_W +: c_ACC_W] = w_hval;
        assign w_wr_all[g*c_ACC_W +: c_ACC_W]   = w_row_first ? w_hval : w_comb;
        // Arithmetic shift floors toward -inf; the mean always fits in BITS.
        assign w_out_all[g*BITS +: BITS] = r_mode ? BITS'(w_comb >>> (2 * K_SHIFT))
                                                  : BITS'(w_comb);
    end

    // Frame control: state, latched mode and raster position counters.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_mode   <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
            r_all_in <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state  <= c_S_RUN;
                        r_mode   <= mode;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_all_in <= 1'b0;
                    end
                end
                c_S_RUN: begin
                    if (w_accept) begin
                        if (w_col_end) begin
                            r_col <= '0;
                            r_row <= w_row_last ? '0 : (r_row + c_ROW_W'(1));
                            if (w_row_last) begin
                                r_all_in <= 1'b1;
                            end
                        end else begin
                            r_col <= r_col + c_COL_W'(1);
                        end
                    end
                    if (w_out_fire && r_out_last) begin
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Horizontal accumulator follows every accepted beat.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_hacc <= '0;
        end else if (w_accept) begin
            r_hacc <= w_hval_all;
        end
    end

    // Row buffer stores group results for every row of a window but the last;
    // it needs no reset because each entry is written before it is read.
    always_ff @(posedge clk_in) begin
        if (w_accept && w_grp_end && !w_row_end) begin
            r_rowbuf[w_gidx] <= w_wr_all;
        end
    end

    // Output register: loads on window completion, clears when consumed.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_win_done) begin
            r_out_valid <= 1'b1;
            r_data_out  <= w_out_all;
            r_out_last  <= w_col_end & w_row_last;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign out_last  = r_out_last;
    assign busy      = (r_state != c_S_IDLE);
    assign done      = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pool_stream_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_stream_top
//  Description : Self-checking bench for pool_stream_top. Three instances
//                (4x4 K=2 CH=2, 24x24 K=2 CH=8, 8x8 K=4 CH=2) share one
//                stimulus/monitor path selected by 'sel'; expected windows
//                come from a direct per-window max / floored-mean model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_stream_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    int           sel;
    logic         start_x, mode_x, in_valid_x, out_ready_x;
    logic [127:0] data_in_x;

    logic         in_ready_x, out_valid_x, out_last_x, busy_x, done_x;
    logic [127:0] data_out_x;

    logic         start_a, in_valid_a, in_ready_a, out_valid_a, out_last_a, busy_a, done_a;
    logic [31:0]  data_out_a;
    logic         start_b, in_valid_b, in_ready_b, out_valid_b, out_last_b, busy_b, done_b;
    logic [127:0] data_out_b;
    logic         start_c, in_valid_c, in_ready_c, out_valid_c, out_last_c, busy_c, done_c;
    logic [31:0]  data_out_c;

    assign start_a    = start_x & (sel == 0);
    assign in_valid_a = in_valid_x & (sel == 0);
    assign start_b    = start_x & (sel == 1);
    assign in_valid_b = in_valid_x & (sel == 1);
    assign start_c    = start_x & (sel == 2);
    assign in_valid_c = in_valid_x & (sel == 2);

    pool_stream_top #(.BITS(16), .CH(2), .IMG_W(4), .IMG_H(4), .K(2), .K_SHIFT(1)) u_dut_a (
        .clk_in(clk), .rst(rst), .start(start_a), .mode(mode_x),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .data_in(data_in_x[31:0]),
        .out_valid(out_valid_a), .out_ready(out_ready_x), .data_out(data_out_a),
        .out_last(out_last_a), .busy(busy_a), .done(done_a));

    pool_stream_top u_dut_b (
        .clk_in(clk), .rst(rst), .start(start_b), .mode(mode_x),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .data_in(data_in_x),
        .out_valid(out_valid_b), .out_ready(out_ready_x), .data_out(data_out_b),
        .out_last(out_last_b), .busy(busy_b), .done(done_b));

    pool_stream_top #(.BITS(16), .CH(2), .IMG_W(8), .IMG_H(8), .K(4), .K_SHIFT(2)) u_dut_c (
        .clk_in(clk), .rst(rst), .start(start_c), .mode(mode_x),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .data_in(data_in_x[31:0]),
        .out_valid(out_valid_c), .out_ready(out_ready_x), .data_out(data_out_c),
        .out_last(out_last_c), .busy(busy_c), .done(done_c));

    // Route the selected instance onto the common observation signals.
    always_comb begin
        in_ready_x  = in_ready_a;
        out_valid_x = out_valid_a;
        out_last_x  = out_last_a;
        busy_x      = busy_a;
        done_x      = done_a;
        data_out_x  = {96'd0, data_out_a};
        case (sel)
            1: begin
                in_ready_x  = in_ready_b;
                out_valid_x = out_valid_b;
                out_last_x  = out_last_b;
                busy_x      = busy_b;
                done_x      = done_b;
                data_out_x  = data_out_b;
            end
            2: begin
                in_ready_x  = in_ready_c;
                out_valid_x = out_valid_c;
                out_last_x  = out_last_c;
                busy_x      = busy_c;
                done_x      = done_c;
                data_out_x  = {96'd0, data_out_c};
            end
            default: ;
        endcase
    end

    int tests = 0;
    int fails = 0;

    int img_w, img_h, kk, nch;
    int pix [0:7][0:23][0:23];
    logic [127:0] exp_q[$];

    task automatic set_dims(input int s);
        sel = s;
        case (s)
            1:       begin img_w = 24; img_h = 24; kk = 2; nch = 8; end
            2:       begin img_w = 8;  img_h = 8;  kk = 4; nch = 2; end
            default: begin img_w = 4;  img_h = 4;  kk = 2; nch = 2; end
        endcase
    endtask

    task automatic fill_ramp(input bit ch1_minus_one);
        for (int r = 0; r < img_h; r++)
            for (int c = 0; c < img_w; c++) begin
                pix[0][r][c] = r * img_w + c;
                pix[1][r][c] = ch1_minus_one ? -1 : -(r * img_w + c);
            end
    endtask

    task automatic fill_const(input int v);
        for (int ch = 0; ch < nch; ch++)
            for (int r = 0; r < img_h; r++)
                for (int c = 0; c < img_w; c++)
                    pix[ch][r][c] = v;
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < nch; ch++)
            for (int r = 0; r < img_h; r++)
                for (int c = 0; c < img_w; c++)
                    pix[ch][r][c] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    // Reference: each window directly as max or floor(sum / K*K).
    task automatic build_expected(input int m);
        exp_q.delete();
        for (int wr = 0; wr < img_h / kk; wr++)
            for (int wc = 0; wc < img_w / kk; wc++) begin
                logic [127:0] w;
                w = '0;
                for (int ch = 0; ch < nch; ch++) begin
                    int acc, res;
                    acc = (m == 0) ? pix[ch][wr*kk][wc*kk] : 0;
                    for (int dy = 0; dy < kk; dy++)
                        for (int dx = 0; dx < kk; dx++) begin
                            int v;
                            v = pix[ch][wr*kk+dy][wc*kk+dx];
                            if (m == 0) acc = (v > acc) ? v : acc;
                            else        acc = acc + v;
                        end
                    if (m == 0) res = acc;
                    else begin
                        res = acc / (kk * kk);
                        if (acc < 0 && (acc % (kk * kk)) != 0) res = res - 1;
                    end
                    w[ch*16 +: 16] = res[15:0];
                end
                exp_q.push_back(w);
            end
    endtask

    task automatic pack_pixel(input int idx);
        int r, c;
        r = idx / img_w;
        c = idx % img_w;
        data_in_x = '0;
        for (int ch = 0; ch < nch; ch++) begin
            int v;
            v = pix[ch][r][c];
            data_in_x[ch*16 +: 16] = v[15:0];
        end
    endtask

    // Runs one frame on the selected instance and checks every output,
    // optional stall window, out_last and the done/busy tail.
    task automatic run_frame(input int m, input int gap_pct, input int rdy_pct,
                             input int stall_n, input bit pulse_start,
                             output int in_cycles);
        int total, cnt, idx, cyc, n, mcyc, stall_left;
        bit v;
        logic [127:0] held;
        total = img_w * img_h;
        cnt   = exp_q.size();
        held  = '0;
        @(negedge clk);
        start_x = 1'b1;
        mode_x  = m[0];
        @(negedge clk);
        start_x = 1'b0;
        tests++;
        if (busy_x !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %b expected 1", busy_x);
        end
        out_ready_x = (rdy_pct >= 100);
        fork
            begin
                idx = 0;
                cyc = 0;
                while (idx < total && cyc < 6000) begin
                    @(negedge clk);
                    #2;
                    cyc++;
                    start_x = pulse_start && (cyc == 4);
                    v = ($urandom_range(0, 99) >= gap_pct);
                    in_valid_x = v;
                    pack_pixel(idx);
                    if (v && in_ready_x) idx++;
                end
                @(negedge clk);
                #2;
                in_valid_x = 1'b0;
                start_x    = 1'b0;
                in_cycles  = cyc;
                if (idx < total) begin
                    tests++;
                    fails++;
                    $display("FAIL input_timeout: accepted %0d expected %0d", idx, total);
                end
            end
            begin
                n = 0;
                mcyc = 0;
                stall_left = stall_n;
                while (n < cnt && mcyc < 6000) begin
                    @(negedge clk);
                    mcyc++;
                    if (stall_left > 0 && out_valid_x) begin
                        out_ready_x = 1'b0;
                        #1;
                        if (stall_left == stall_n) held = data_out_x;
                        else begin
                            tests++;
                            if (data_out_x !== held) begin
                                fails++;
                                $display("FAIL stall_hold: got %h expected %h", data_out_x, held);
                            end
                        end
                        tests++;
                        if (in_ready_x !== 1'b0) begin
                            fails++;
                            $display("FAIL stall_in_ready: got %b expected 0", in_ready_x);
                        end
                        stall_left--;
                    end else begin
                        out_ready_x = ($urandom_range(0, 99) < rdy_pct);
                        if (out_valid_x && out_ready_x) begin
                            tests++;
                            if (data_out_x !== exp_q[n]) begin
                                fails++;
                                $display("FAIL out_data[%0d]: got %h expected %h", n, data_out_x, exp_q[n]);
                            end
                            tests++;
                            if (out_last_x !== 1'(n == cnt - 1)) begin
                                fails++;
                                $display("FAIL out_last[%0d]: got %b expected %b", n, out_last_x, (n == cnt - 1));
                            end
                            n++;
                        end
                    end
                end
                if (n < cnt) begin
                    tests++;
                    fails++;
                    $display("FAIL output_timeout: got %0d outputs expected %0d", n, cnt);
                end else begin
                    @(negedge clk);
                    tests++;
                    if (done_x !== 1'b1 || busy_x !== 1'b1 || out_valid_x !== 1'b0) begin
                        fails++;
                        $display("FAIL done_pulse: got done=%b busy=%b valid=%b expected 1 1 0",
                                 done_x, busy_x, out_valid_x);
                    end
                    @(negedge clk);
                    tests++;
                    if (done_x !== 1'b0 || busy_x !== 1'b0) begin
                        fails++;
                        $display("FAIL done_fall: got done=%b busy=%b expected 0 0", done_x, busy_x);
                    end
                end
            end
        join
        out_ready_x = 1'b1;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            tests++;
            if ({in_ready_x, out_valid_x, out_last_x, busy_x, done_x} !== 5'b0 || data_out_x !== '0) begin
                fails++;
                $display("FAIL reset_state[%0d]: got rdy=%b val=%b last=%b busy=%b done=%b data=%h expected all 0",
                         s, in_ready_x, out_valid_x, out_last_x, busy_x, done_x, data_out_x);
            end
        end
    endtask

    task automatic test_max_small();
        int cyc;
        set_dims(0);
        fill_ramp(1'b0);
        build_expected(0);
        run_frame(0, 0, 100, 0, 1'b0, cyc);
        tests++;
        if (cyc !== 16) begin
            fails++;
            $display("FAIL max_throughput: got %0d cycles expected 16", cyc);
        end
    endtask

    task automatic test_avg_small();
        int cyc;
        set_dims(0);
        fill_ramp(1'b1);
        build_expected(1);
        run_frame(1, 0, 100, 0, 1'b0, cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        set_dims(0);
        fill_ramp(1'b0);
        build_expected(0);
        run_frame(0, 0, 100, 5, 1'b0, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        set_dims(0);
        for (int f = 0; f < 2; f++) begin
            fill_random();
            build_expected(f);
            run_frame(f, 0, 100, 0, 1'b0, cyc);
            tests++;
            if (cyc !== 16) begin
                fails++;
                $display("FAIL b2b_throughput[%0d]: got %0d cycles expected 16", f, cyc);
            end
        end
    endtask

    task automatic test_avg_k4();
        int cyc;
        set_dims(2);
        fill_const(32767);
        build_expected(1);
        run_frame(1, 0, 100, 0, 1'b0, cyc);
        fill_const(-32768);
        build_expected(1);
        run_frame(1, 0, 100, 0, 1'b0, cyc);
        fill_random();
        build_expected(1);
        run_frame(1, 30, 60, 0, 1'b0, cyc);
        fill_random();
        build_expected(0);
        run_frame(0, 30, 60, 0, 1'b0, cyc);
    endtask

    task automatic test_random_full();
        int cyc;
        set_dims(1);
        for (int m = 0; m < 2; m++) begin
            fill_random();
            build_expected(m);
            run_frame(m, 50, 50, 0, 1'b1, cyc);
        end
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        set_dims(0);
        fill_random();
        @(negedge clk);
        start_x = 1'b1;
        mode_x  = 1'b1;
        @(negedge clk);
        start_x     = 1'b0;
        out_ready_x = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 100) begin
            @(negedge clk);
            #2;
            cyc++;
            in_valid_x = 1'b1;
            pack_pixel(n);
            if (in_ready_x) n++;
        end
        @(negedge clk);
        in_valid_x = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({in_ready_x, out_valid_x, busy_x, done_x} !== 4'b0 || data_out_x !== '0) begin
            fails++;
            $display("FAIL mid_reset: got rdy=%b val=%b busy=%b done=%b data=%h expected all 0",
                     in_ready_x, out_valid_x, busy_x, done_x, data_out_x);
        end
        rst = 1'b0;
        fill_ramp(1'b0);
        build_expected(0);
        run_frame(0, 20, 80, 0, 1'b0, cyc);
    endtask

    initial begin
        rst         = 1'b1;
        sel         = 0;
        start_x     = 1'b0;
        mode_x      = 1'b0;
        in_valid_x  = 1'b0;
        out_ready_x = 1'b1;
        data_in_x   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_max_small();
        test_avg_small();
        test_backpressure();
        test_back_to_back();
        test_avg_k4();
        test_random_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
